id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register and hazard stage. Sits directly downstream of the register file.
//  - Captures the register-file read operands and the decoded fields into the EX stage.
//  - Applies the WB->ID same-cycle bypass and forces register 0 to zero.
//  - Detects load-use hazards and stalls ID/IF, inserting a bubble into EX.
//  - Counts stall cycles.
// PARAMETERS
//  DATA_W   32  operand/immediate width
//  REG_W    5   register-number width
//  CTRL_W   8   opaque EX/MEM/WB control bundle width, passed through untouched
//  CNT_W    16  stall counter width
// PORTS
//  clk           in   1        rising-edge clock
//  reset         in   1        asynchronous, active-low; clears all state
//  id_valid      in   1        ID holds a real instruction
//  id_rs         in   REG_W    source reg 1 (also drives register-file Read_Reg1)
//  id_rt         in   REG_W    source reg 2 (also drives register-file Read_Reg2)
//  id_uses_rt    in   1        instruction reads rt (R-type, store, branch)
//  id_dst        in   REG_W    resolved destination register
//  id_rdata1     in   DATA_W   register-file Read_Data1
//  id_rdata2     in   DATA_W   register-file Read_Data2
//  id_imm        in   DATA_W   sign/zero-extended immediate
//  id_ctrl       in   CTRL_W   decoded control bundle
//  id_mem_read   in   1        instruction is a load
//  id_reg_write  in   1        instruction writes a register
//  wb_reg_write  in   1        WB write enable (same signal as register-file RegWrite)
//  wb_dst        in   REG_W    WB destination (register-file Write_Reg_Num)
//  wb_data       in   DATA_W   WB data (register-file reg_write_data)
//  flush         in   1        branch/jump taken: squash the ID instruction
//  hold          in   1        global freeze (memory wait)
//  stall_id      out  1        combinational: freeze PC and IF/ID this cycle
//  ex_valid      out  1        EX holds a real instruction
//  ex_rs/ex_rt   out  REG_W    latched source numbers, for the forwarding unit
//  ex_dst        out  REG_W    latched destination
//  ex_op_a       out  DATA_W   latched operand A
//  ex_op_b       out  DATA_W   latched operand B
//  ex_imm        out  DATA_W   latched immediate
//  ex_ctrl       out  CTRL_W   latched control bundle
//  ex_mem_read   out  1        latched load flag
//  ex_reg_write  out  1        latched write flag
//  stall_cnt     out  CNT_W    number of load-use stall cycles, saturating
// BEHAVIOUR
//  Reset (async, reset==0):
//   - All ex_* outputs are 0 and stall_cnt is 0; holds regardless of clk.
//   - Asserting reset mid-operation discards the EX contents immediately.
//  Operand select (combinational, per source):
//   - Register 0 reads as 0.
//   - Otherwise, if wb_reg_write && wb_dst==src, use wb_data.
//   - Otherwise use id_rdataN.
//   - The bypass is needed because the register file commits on the same clock edge.
//  Load-use hazard (lu):
//   - lu = ex_valid & ex_mem_read & ex_reg_write & ex_dst!=0 & id_valid
//     & (id_rs==ex_dst | (id_uses_rt & id_rt==ex_dst)).
//   - stall_id = hold | (lu & ~flush).
//  EX register update at posedge clk, priority order:
//   1. hold: all ex_* and stall_cnt keep their values. A flush requested during hold is
//      not acted on; upstream must keep flush asserted until hold drops.
//   2. flush: load a bubble (ex_valid, ex_mem_read, ex_reg_write, ex_ctrl = 0; other
//      fields don't-care, driven to 0).
//   3. lu: load a bubble; stall_cnt += 1, saturating at all-ones (never wraps to 0).
//   4. Otherwise, capture all id_* fields. ex_valid=id_valid. The control bits
//      (ex_mem_read, ex_reg_write, ex_ctrl) are gated to 0 when id_valid==0.
//  Timing:
//   - Latency is one cycle, ID to EX.
//   - A load-use pair costs exactly one bubble. On the next cycle the load has left EX,
//     so lu deasserts unless a new load is in EX.
//   - flush and lu in the same cycle: flush wins; no stall, and stall_cnt is not
//     incremented.
// TESTING
//  T1 reset: assert reset low mid-stream with ex_valid=1 -> all ex_*=0 and stall_cnt=0
//     before the next edge.
//  T2 bypass: id_rs=5, rdata1=0x11, wb_reg_write=1, wb_dst=5, wb_data=0xAB
//     -> ex_op_a=0xAB after the edge. Same stimulus with id_rs=0 -> ex_op_a=0.
//  T3 load-use: EX holds lw $8; ID add $9,$8,$3 -> stall_id=1; next cycle ex_valid=0,
//     stall_cnt=1; following cycle the add enters EX.
//  T4 rt unused: EX holds lw $8; ID addi $9,$2,4 with id_rt=8, id_uses_rt=0 -> no stall.
//  T5 flush+lu: same setup as T3 with flush=1 -> stall_id=0, bubble, stall_cnt unchanged.
//  T6 hold/saturate: hold=1 for 3 cycles -> ex_* frozen. Preload stall_cnt=0xFFFF,
//     then lu -> stall_cnt stays 0xFFFF.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - ID/EX stage signal bundle
// Ports (slave view, as seen by id_ex_stage):
//   in : id_valid id_rs id_rt id_uses_rt id_dst id_rdata1 id_rdata2 id_imm id_ctrl
//        id_mem_read id_reg_write wb_reg_write wb_dst wb_data flush hold
//   out: stall_id ex_valid ex_rs ex_rt ex_dst ex_op_a ex_op_b ex_imm ex_ctrl
//        ex_mem_read ex_reg_write stall_cnt
interface id_ex_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic [REG_W-1:0]  id_rs;
  logic [REG_W-1:0]  id_rt;
  logic              id_uses_rt;
  logic [REG_W-1:0]  id_dst;
  logic [DATA_W-1:0] id_rdata1;
  logic [DATA_W-1:0] id_rdata2;
  logic [DATA_W-1:0] id_imm;
  logic [CTRL_W-1:0] id_ctrl;
  logic              id_mem_read;
  logic              id_reg_write;
  logic              wb_reg_write;
  logic [REG_W-1:0]  wb_dst;
  logic [DATA_W-1:0] wb_data;
  logic              flush;
  logic              hold;
  logic              stall_id;
  logic              ex_valid;
  logic [REG_W-1:0]  ex_rs;
  logic [REG_W-1:0]  ex_rt;
  logic [REG_W-1:0]  ex_dst;
  logic [DATA_W-1:0] ex_op_a;
  logic [DATA_W-1:0] ex_op_b;
  logic [DATA_W-1:0] ex_imm;
  logic [CTRL_W-1:0] ex_ctrl;
  logic              ex_mem_read;
  logic              ex_reg_write;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rt, id_dst, id_rdata1, id_rdata2, id_imm,
           id_ctrl, id_mem_read, id_reg_write, wb_reg_write, wb_dst, wb_data, flush, hold,
    input  stall_id, ex_valid, ex_rs, ex_rt, ex_dst, ex_op_a, ex_op_b, ex_imm, ex_ctrl,
           ex_mem_read, ex_reg_write, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rt, id_dst, id_rdata1, id_rdata2, id_imm,
           id_ctrl, id_mem_read, id_reg_write, wb_reg_write, wb_dst, wb_data, flush, hold,
    output stall_id, ex_valid, ex_rs, ex_rt, ex_dst, ex_op_a, ex_op_b, ex_imm, ex_ctrl,
           ex_mem_read, ex_reg_write, stall_cnt
  );
endinterface

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with WB bypass and load-use stall
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-low; clears all EX state and the stall counter
//   bus   : id_ex_stage_if.slave (ID fields and WB write port in, EX fields,
//           stall_id and stall_cnt out)
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input logic   clk,
  input logic   reset,
  id_ex_stage_if.slave bus
);

  logic              ex_valid_q;
  logic [REG_W-1:0]  ex_rs_q;
  logic [REG_W-1:0]  ex_rt_q;
  logic [REG_W-1:0]  ex_dst_q;
  logic [DATA_W-1:0] ex_op_a_q;
  logic [DATA_W-1:0] ex_op_b_q;
  logic [DATA_W-1:0] ex_imm_q;
  logic [CTRL_W-1:0] ex_ctrl_q;
  logic              ex_mem_read_q;
  logic              ex_reg_write_q;
  logic [CNT_W-1:0]  stall_cnt_q;

  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              lu;

  // The register file commits WB on the same edge that EX captures, so its read
  // port still shows the old value; take the WB data directly instead.
  always_comb begin
    op_a = bus.id_rdata1;
    if (bus.id_rs == '0)
      op_a = '0;
    else if (bus.wb_reg_write && (bus.wb_dst == bus.id_rs))
      op_a = bus.wb_data;
  end

  always_comb begin
    op_b = bus.id_rdata2;
    if (bus.id_rt == '0)
      op_b = '0;
    else if (bus.wb_reg_write && (bus.wb_dst == bus.id_rt))
      op_b = bus.wb_data;
  end

  // A load in EX has no data until MEM, so a dependent instruction in ID must wait.
  assign lu = ex_valid_q && ex_mem_read_q && ex_reg_write_q && (ex_dst_q != '0) &&
              bus.id_valid &&
              ((bus.id_rs == ex_dst_q) || (bus.id_uses_rt && (bus.id_rt == ex_dst_q)));

  // A flushed ID instruction is squashed anyway, so it never needs to stall.
  assign bus.stall_id = bus.hold || (lu && !bus.flush);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid_q     <= 1'b0;
      ex_rs_q        <= '0;
      ex_rt_q        <= '0;
      ex_dst_q       <= '0;
      ex_op_a_q      <= '0;
      ex_op_b_q      <= '0;
      ex_imm_q       <= '0;
      ex_ctrl_q      <= '0;
      ex_mem_read_q  <= 1'b0;
      ex_reg_write_q <= 1'b0;
      stall_cnt_q    <= '0;
    end else if (bus.hold) begin
      // Freeze everything, including any pending flush.
    end else if (bus.flush || lu) begin
      ex_valid_q     <= 1'b0;
      ex_rs_q        <= '0;
      ex_rt_q        <= '0;
      ex_dst_q       <= '0;
      ex_op_a_q      <= '0;
      ex_op_b_q      <= '0;
      ex_imm_q       <= '0;
      ex_ctrl_q      <= '0;
      ex_mem_read_q  <= 1'b0;
      ex_reg_write_q <= 1'b0;
      // Only a genuine load-use bubble is a stall; flush takes priority.
      if (!bus.flush && (stall_cnt_q != {CNT_W{1'b1}}))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end else begin
      ex_valid_q     <= bus.id_valid;
      ex_rs_q        <= bus.id_rs;
      ex_rt_q        <= bus.id_rt;
      ex_dst_q       <= bus.id_dst;
      ex_op_a_q      <= op_a;
      ex_op_b_q      <= op_b;
      ex_imm_q       <= bus.id_imm;
      ex_ctrl_q      <= bus.id_valid ? bus.id_ctrl : '0;
      ex_mem_read_q  <= bus.id_valid && bus.id_mem_read;
      ex_reg_write_q <= bus.id_valid && bus.id_reg_write;
    end
  end

  assign bus.ex_valid     = ex_valid_q;
  assign bus.ex_rs        = ex_rs_q;
  assign bus.ex_rt        = ex_rt_q;
  assign bus.ex_dst       = ex_dst_q;
  assign bus.ex_op_a      = ex_op_a_q;
  assign bus.ex_op_b      = ex_op_b_q;
  assign bus.ex_imm       = ex_imm_q;
  assign bus.ex_ctrl      = ex_ctrl_q;
  assign bus.ex_mem_read  = ex_mem_read_q;
  assign bus.ex_reg_write = ex_reg_write_q;
  assign bus.stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed self-checking bench for id_ex_stage
module tb_id_ex_stage;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  id_ex_stage_if #(.DATA_W(32), .REG_W(5), .CTRL_W(8), .CNT_W(16)) bus ();
  id_ex_stage_if #(.DATA_W(32), .REG_W(5), .CTRL_W(8), .CNT_W(3))  sbus ();

  id_ex_stage #(.DATA_W(32), .REG_W(5), .CTRL_W(8), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave));

  // Narrow counter instance so saturation is reachable in a few cycles.
  id_ex_stage #(.DATA_W(32), .REG_W(5), .CTRL_W(8), .CNT_W(3)) dut_sat (
    .clk(clk), .reset(reset), .bus(sbus.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic urt, input logic [4:0] dst,
                          input logic [31:0] rd1, input logic [31:0] rd2,
                          input logic [31:0] imm, input logic [7:0] ctrl,
                          input logic mr, input logic rw);
    bus.id_valid = v; bus.id_rs = rs; bus.id_rt = rt; bus.id_uses_rt = urt;
    bus.id_dst = dst; bus.id_rdata1 = rd1; bus.id_rdata2 = rd2; bus.id_imm = imm;
    bus.id_ctrl = ctrl; bus.id_mem_read = mr; bus.id_reg_write = rw;
  endtask

  task automatic idle();
    drive_id(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 8'h0, 1'b0, 1'b0);
    bus.wb_reg_write = 1'b0; bus.wb_dst = 5'd0; bus.wb_data = 32'h0;
    bus.flush = 1'b0; bus.hold = 1'b0;
  endtask

  task automatic sat_drive(input logic v, input logic [4:0] rs, input logic [4:0] dst,
                           input logic mr);
    sbus.id_valid = v; sbus.id_rs = rs; sbus.id_rt = 5'd0; sbus.id_uses_rt = 1'b0;
    sbus.id_dst = dst; sbus.id_rdata1 = 32'h0; sbus.id_rdata2 = 32'h0; sbus.id_imm = 32'h0;
    sbus.id_ctrl = 8'h0; sbus.id_mem_read = mr; sbus.id_reg_write = 1'b1;
    sbus.wb_reg_write = 1'b0; sbus.wb_dst = 5'd0; sbus.wb_data = 32'h0;
    sbus.flush = 1'b0; sbus.hold = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle();
    sat_drive(1'b0, 5'd0, 5'd0, 1'b0);
    #3;
    checks++; if (bus.ex_valid !== 1'b0) begin errors++; $display("FAIL reset_ex_valid: got %b expected 0", bus.ex_valid); end
    checks++; if (bus.stall_cnt !== 16'h0) begin errors++; $display("FAIL reset_stall_cnt: got %h expected 0000", bus.stall_cnt); end
    #9 reset = 1'b1;
    drive_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 32'h55, 32'h66, 32'h7, 8'hC3, 1'b1, 1'b1);
    step();
    checks++; if (bus.ex_valid !== 1'b1) begin errors++; $display("FAIL prereset_ex_valid: got %b expected 1", bus.ex_valid); end
    #2 reset = 1'b0;
    #1;
    checks++; if (bus.ex_valid !== 1'b0) begin errors++; $display("FAIL midreset_ex_valid: got %b expected 0", bus.ex_valid); end
    checks++; if (bus.ex_op_a !== 32'h0) begin errors++; $display("FAIL midreset_ex_op_a: got %h expected 0", bus.ex_op_a); end
    checks++; if (bus.ex_ctrl !== 8'h0) begin errors++; $display("FAIL midreset_ex_ctrl: got %h expected 00", bus.ex_ctrl); end
    checks++; if (bus.ex_reg_write !== 1'b0 || bus.ex_mem_read !== 1'b0) begin errors++; $display("FAIL midreset_ex_flags: got %b%b expected 00", bus.ex_mem_read, bus.ex_reg_write); end
    #1 reset = 1'b1;
    idle();
  endtask

  task automatic test_bypass();
    drive_id(1'b1, 5'd5, 5'd6, 1'b1, 5'd7, 32'h11, 32'h22, 32'h0, 8'h01, 1'b0, 1'b1);
    bus.wb_reg_write = 1'b1; bus.wb_dst = 5'd5; bus.wb_data = 32'hAB;
    step();
    checks++; if (bus.ex_op_a !== 32'hAB) begin errors++; $display("FAIL bypass_op_a: got %h expected 000000ab", bus.ex_op_a); end
    checks++; if (bus.ex_op_b !== 32'h22) begin errors++; $display("FAIL bypass_op_b_nomatch: got %h expected 00000022", bus.ex_op_b); end
    bus.id_rs = 5'd0;
    step();
    checks++; if (bus.ex_op_a !== 32'h0) begin errors++; $display("FAIL r0_op_a: got %h expected 0", bus.ex_op_a); end
    bus.id_rs = 5'd5; bus.wb_reg_write = 1'b0;
    step();
    checks++; if (bus.ex_op_a !== 32'h11) begin errors++; $display("FAIL nobypass_op_a: got %h expected 00000011", bus.ex_op_a); end
    bus.id_rt = 5'd5; bus.wb_reg_write = 1'b1;
    step();
    checks++; if (bus.ex_op_b !== 32'hAB) begin errors++; $display("FAIL bypass_op_b: got %h expected 000000ab", bus.ex_op_b); end
    idle();
  endtask

  task automatic test_capture();
    drive_id(1'b1, 5'd4, 5'd12, 1'b1, 5'd9, 32'h100, 32'h200, 32'h1234, 8'h5A, 1'b0, 1'b1);
    step();
    checks++; if (bus.ex_ctrl !== 8'h5A) begin errors++; $display("FAIL cap_ctrl: got %h expected 5a", bus.ex_ctrl); end
    checks++; if (bus.ex_imm !== 32'h1234 || bus.ex_dst !== 5'd9 || bus.ex_rt !== 5'd12) begin errors++; $display("FAIL cap_fields: got imm=%h dst=%0d rt=%0d expected imm=00001234 dst=9 rt=12", bus.ex_imm, bus.ex_dst, bus.ex_rt); end
    drive_id(1'b0, 5'd4, 5'd12, 1'b1, 5'd9, 32'h100, 32'h200, 32'h99, 8'hFF, 1'b1, 1'b1);
    step();
    checks++; if (bus.ex_valid !== 1'b0 || bus.ex_ctrl !== 8'h0 || bus.ex_mem_read !== 1'b0 || bus.ex_reg_write !== 1'b0) begin errors++; $display("FAIL gate_invalid: got v=%b ctrl=%h mr=%b rw=%b expected 0 00 0 0", bus.ex_valid, bus.ex_ctrl, bus.ex_mem_read, bus.ex_reg_write); end
    checks++; if (bus.ex_imm !== 32'h99) begin errors++; $display("FAIL gate_imm: got %h expected 00000099", bus.ex_imm); end
    idle();
  endtask

  task automatic load_lw8();
    drive_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd8, 32'h10, 32'h0, 32'h4, 8'h81, 1'b1, 1'b1);
    step();
  endtask

  task automatic test_load_use();
    load_lw8();
    drive_id(1'b1, 5'd8, 5'd3, 1'b1, 5'd9, 32'h0, 32'h3, 32'h0, 8'h02, 1'b0, 1'b1);
    #1;
    checks++; if (bus.stall_id !== 1'b1) begin errors++; $display("FAIL lu_stall_id: got %b expected 1", bus.stall_id); end
    step();
    checks++; if (bus.ex_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble: got %b expected 0", bus.ex_valid); end
    checks++; if (bus.stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_cnt: got %0d expected 1", bus.stall_cnt); end
    checks++; if (bus.stall_id !== 1'b0) begin errors++; $display("FAIL lu_release: got %b expected 0", bus.stall_id); end
    step();
    checks++; if (bus.ex_valid !== 1'b1 || bus.ex_dst !== 5'd9 || bus.ex_rs !== 5'd8) begin errors++; $display("FAIL lu_add_enters: got v=%b dst=%0d rs=%0d expected 1 9 8", bus.ex_valid, bus.ex_dst, bus.ex_rs); end
    checks++; if (bus.stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_cnt_once: got %0d expected 1", bus.stall_cnt); end
    idle();
  endtask

  task automatic test_rt_unused();
    load_lw8();
    drive_id(1'b1, 5'd2, 5'd8, 1'b1, 5'd9, 32'h20, 32'h0, 32'h4, 8'h03, 1'b0, 1'b1);
    #1;
    checks++; if (bus.stall_id !== 1'b1) begin errors++; $display("FAIL rt_used_stall: got %b expected 1", bus.stall_id); end
    bus.id_uses_rt = 1'b0;
    #1;
    checks++; if (bus.stall_id !== 1'b0) begin errors++; $display("FAIL rt_unused_stall: got %b expected 0", bus.stall_id); end
    step();
    checks++; if (bus.ex_valid !== 1'b1 || bus.ex_dst !== 5'd9 || bus.ex_op_a !== 32'h20) begin errors++; $display("FAIL rt_unused_capture: got v=%b dst=%0d a=%h expected 1 9 00000020", bus.ex_valid, bus.ex_dst, bus.ex_op_a); end
    checks++; if (bus.stall_cnt !== 16'd1) begin errors++; $display("FAIL rt_unused_cnt: got %0d expected 1", bus.stall_cnt); end
    idle();
  endtask

  task automatic test_flush_lu();
    load_lw8();
    drive_id(1'b1, 5'd8, 5'd3, 1'b1, 5'd9, 32'h0, 32'h3, 32'h0, 8'h02, 1'b0, 1'b1);
    bus.flush = 1'b1;
    #1;
    checks++; if (bus.stall_id !== 1'b0) begin errors++; $display("FAIL flush_lu_stall: got %b expected 0", bus.stall_id); end
    step();
    checks++; if (bus.ex_valid !== 1'b0 || bus.ex_ctrl !== 8'h0 || bus.ex_reg_write !== 1'b0) begin errors++; $display("FAIL flush_bubble: got v=%b ctrl=%h rw=%b expected 0 00 0", bus.ex_valid, bus.ex_ctrl, bus.ex_reg_write); end
    checks++; if (bus.stall_cnt !== 16'd1) begin errors++; $display("FAIL flush_cnt: got %0d expected 1", bus.stall_cnt); end
    idle();
  endtask

  task automatic test_hold();
    load_lw8();
    drive_id(1'b1, 5'd8, 5'd3, 1'b1, 5'd9, 32'h0, 32'h3, 32'h0, 8'h02, 1'b0, 1'b1);
    bus.hold = 1'b1;
    #1;
    checks++; if (bus.stall_id !== 1'b1) begin errors++; $display("FAIL hold_stall_id: got %b expected 1", bus.stall_id); end
    for (int i = 0; i < 3; i++) begin
      bus.flush = (i == 1);
      step();
      checks++; if (bus.ex_valid !== 1'b1 || bus.ex_dst !== 5'd8 || bus.ex_mem_read !== 1'b1 || bus.ex_ctrl !== 8'h81 || bus.ex_op_a !== 32'h10) begin errors++; $display("FAIL hold_frozen_%0d: got v=%b dst=%0d mr=%b ctrl=%h a=%h expected 1 8 1 81 00000010", i, bus.ex_valid, bus.ex_dst, bus.ex_mem_read, bus.ex_ctrl, bus.ex_op_a); end
      checks++; if (bus.stall_cnt !== 16'd1) begin errors++; $display("FAIL hold_cnt_%0d: got %0d expected 1", i, bus.stall_cnt); end
    end
    bus.flush = 1'b0; bus.hold = 1'b0;
    step();
    checks++; if (bus.stall_cnt !== 16'd2 || bus.ex_valid !== 1'b0) begin errors++; $display("FAIL post_hold_lu: got cnt=%0d v=%b expected 2 0", bus.stall_cnt, bus.ex_valid); end
    idle();
  endtask

  task automatic test_saturate();
    int exp_cnt;
    exp_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      sat_drive(1'b1, 5'd1, 5'd8, 1'b1);
      step();
      sat_drive(1'b1, 5'd8, 5'd9, 1'b0);
      step();
      if (exp_cnt < 7) exp_cnt++;
      checks++; if (sbus.stall_cnt !== 3'(exp_cnt)) begin errors++; $display("FAIL sat_cnt_%0d: got %0d expected %0d", i, sbus.stall_cnt, exp_cnt); end
    end
    sat_drive(1'b0, 5'd0, 5'd0, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_bypass();
    test_capture();
    test_load_use();
    test_rt_unused();
    test_flush_lu();
    test_hold();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
